// File: rtl/tdm_demux_1x8_pkg.sv
// tdm_pkg: slot geometry, FSM states and lane-slice helpers shared by the TDM mux/demux pair
package tdm_pkg;
   localparam int NUM_SLOTS = 8;
   localparam int SLOT_W = 3;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
   typedef enum logic {S_IDLE, S_COLLECT} state_e;
   function automatic int unsigned lane_lo(input int unsigned k, input int unsigned dw);
      return k * dw;
   endfunction
endpackage

// File: rtl/tdm_demux_1x8_slot_counter.sv
// slot_counter: wrapping slot index with enable and synchronous load-to-1
module slot_counter
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              load1_i,
   output logic [SLOT_W-1:0] cnt_o
);
   logic [SLOT_W-1:0] cnt_q, cnt_d;
   assign cnt_o = cnt_q;
   always_comb cnt_d = load1_i ? SLOT_W'(1) : en_i ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/tdm_demux_1x8.sv
// tdm_demux_1x8: serial 8-slot TDM lane to registered 8-lane frame with valid/ready output
module tdm_demux_1x8
   import tdm_pkg::*;
#(
   parameter int DW = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DW-1:0]          din,
   input  logic                   din_valid,
   input  logic                   sof,
   output logic [NUM_SLOTS*DW-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SLOT_W-1:0]      slot,
   output logic                   sync_err,
   output logic                   overrun
);
   state_e                            state_q, state_d;
   logic [NUM_SLOTS-2:0][DW-1:0]      shadow_q, shadow_d;
   logic [NUM_SLOTS*DW-1:0]           data_q, data_d;
   logic                              valid_q, valid_d, sync_q, sync_d, ovr_q, ovr_d;
   logic                              load, adv, done, take;
   slot_counter u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (adv),
      .load1_i(load),
      .cnt_o  (slot)
   );
   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign sync_err  = sync_q;
   assign overrun   = ovr_q;
   always_comb begin
      load     = din_valid && sof;
      adv      = din_valid && !sof && state_q == S_COLLECT;
      done     = adv && slot == LAST_SLOT;
      take     = done && (!valid_q || out_ready);
      shadow_d = shadow_q;
      if (load) shadow_d[0] = din;
      else if (adv && !done) shadow_d[slot] = din;
      // lane 7 bypasses the shadow and lands directly in the output word
      data_d   = take ? {din, shadow_q} : data_q;
      valid_d  = take ? 1'b1 : (valid_q && out_ready) ? 1'b0 : valid_q;
      sync_d   = load && state_q == S_COLLECT;
      ovr_d    = done && !take;
      state_d  = load ? S_COLLECT : done ? S_IDLE : state_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= S_IDLE;
         shadow_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         sync_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         sync_q   <= sync_d;
         ovr_q    <= ovr_d;
      end
endmodule

// File: tb/tb_tdm_demux_1x8.sv
// tb_tdm_demux_1x8: directed scenarios plus random traffic against a frame-level reference model
module tb_tdm_demux_1x8;
   localparam int DW = 4;
   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [DW-1:0]   din = '0;
   logic            din_valid = 1'b0, sof = 1'b0, out_ready = 1'b0;
   logic [8*DW-1:0] out_data;
   logic            out_valid, sync_err, overrun;
   logic [2:0]      slot;
   int n_checks = 0, n_errors = 0;
   logic [DW-1:0]   m_lane [8];
   int              m_pos;
   bit              m_in_frame, m_valid, m_sync, m_ovr;
   logic [8*DW-1:0] m_data;
   tdm_demux_1x8 #(.DW(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din),
      .din_valid(din_valid),
      .sof      (sof),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .slot     (slot),
      .sync_err (sync_err),
      .overrun  (overrun)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      foreach (m_lane[k]) m_lane[k] = '0;
      m_pos = 0;
      m_in_frame = 0;
      m_valid = 0;
      m_sync = 0;
      m_ovr = 0;
      m_data = '0;
   endtask
   task automatic check_all();
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("slot", 64'(slot), 64'(m_pos));
      chk("sync_err", 64'(sync_err), 64'(m_sync));
      chk("overrun", 64'(overrun), 64'(m_ovr));
   endtask
   // one clock: drive inputs, advance the model, check after the edge
   task automatic step(input bit dv, input bit sf, input logic [DW-1:0] d, input bit rdy);
      bit done;
      din_valid = dv;
      sof = sf;
      din = d;
      out_ready = rdy;
      done = 0;
      m_sync = 0;
      m_ovr = 0;
      if (dv && sf) begin
         m_sync = m_in_frame;
         m_lane[0] = d;
         m_pos = 1;
         m_in_frame = 1;
      end else if (dv && m_in_frame) begin
         m_lane[m_pos] = d;
         if (m_pos == 7) begin
            done = 1;
            m_in_frame = 0;
            m_pos = 0;
         end else m_pos++;
      end
      if (done) begin
         if (!m_valid || rdy) begin
            for (int k = 0; k < 8; k++) m_data[k*DW +: DW] = m_lane[k];
            m_valid = 1;
         end else m_ovr = 1;
      end else if (m_valid && rdy) m_valid = 0;
      @(posedge clk);
      #1;
      check_all();
   endtask
   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 0, '0, rdy);
   endtask
   task automatic frame(input logic [8*DW-1:0] w, input bit rdy, input bit stalls);
      for (int k = 0; k < 8; k++) begin
         step(1, k == 0, w[k*DW +: DW], rdy);
         if (stalls && (k == 2 || k == 5)) idle(3, rdy);
      end
   endtask
   initial begin
      logic [8*DW-1:0] fa, fb, pat;
      model_reset();
      #1;
      check_all();
      #12 rst_n = 1'b1;
      @(negedge clk);
      idle(1, 0);
      pat = 32'h0100_1101;
      frame(pat, 0, 0);
      chk("basic_word", 64'(out_data), 64'(pat));
      idle(1, 1);
      frame(pat, 0, 1);
      chk("stall_word", 64'(out_data), 64'(pat));
      idle(1, 1);
      step(0, 0, '0, 0);
      for (int k = 0; k < 4; k++) step(1, k == 0, DW'(k + 3), 0);
      fa = 32'h1010_0101;
      frame(fa, 0, 0);
      chk("resync_word", 64'(out_data), 64'(fa));
      fb = 32'hCAFE_0042;
      frame(fb, 0, 0);
      chk("overrun_keeps_a", 64'(out_data), 64'(fa));
      idle(2, 1);
      chk("drop_valid", 64'(out_valid), 64'd0);
      frame(fa, 0, 0);
      for (int k = 0; k < 8; k++) step(1, k == 0, fb[k*DW +: DW], k == 7);
      chk("concurrent_word", 64'(out_data), 64'(fb));
      idle(1, 1);
      for (int k = 0; k < 5; k++) step(1, k == 0, DW'(k + 9), 0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      frame(fb, 1, 0);
      chk("post_reset_word", 64'(out_data), 64'(fb));
      repeat (3000) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
              DW'($urandom), $urandom_range(0, 1) == 1);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
